// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: segment/select polarity, controller states,
// and the hex-to-segment encoder for common-anode displays.
package seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam int         DP_BIT  = 7;
    localparam logic       SEL_ON  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH
    } scan_state_t;

    // Active-low segments, seg[7] = dp, seg[6:0] = g..a; dp is off here.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hF8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h90;
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hC6;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

    function automatic logic [7:0] encode_digit(
        input logic [3:0] nib,
        input logic       dp_on,
        input logic       dark
    );
        logic [7:0] seg;
        seg = hex_to_seg(nib);
        if (dp_on) begin
            seg[DP_BIT] = 1'b0;
        end
        if (dark) begin
            seg = SEG_OFF;
        end
        return seg;
    endfunction

endpackage

// File: rtl/hc595_shift.sv
// Generic 74HC595 frame serialiser: shifts WIDTH bits MSB first with a
// divided shift clock, then emits a one-cycle storage-clock pulse.
module hc595_shift #(
    parameter int WIDTH    = 14,
    parameter int SHCP_DIV = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] word_i,
    output logic             shcp_o,
    output logic             ds_o,
    output logic             stcp_o,
    output logic             done_o
);

    localparam int DIV_W = $clog2(SHCP_DIV);
    localparam int BIT_W = $clog2(WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SHCP_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SHCP_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             busy_q, busy_d;
    logic             shcp_q, shcp_d;
    logic             ds_q, ds_d;
    logic             stcp_q, stcp_d;

    always_comb begin
        shreg_d = shreg_q;
        div_d   = div_q;
        bit_d   = bit_q;
        busy_d  = busy_q;
        shcp_d  = 1'b0;
        ds_d    = 1'b0;
        stcp_d  = 1'b0;
        if (!busy_q) begin
            if (start_i) begin
                shreg_d = word_i;
                div_d   = '0;
                bit_d   = '0;
                busy_d  = 1'b1;
                ds_d    = word_i[WIDTH-1];
            end
        end else if (div_q == DIV_LAST) begin
            if (bit_q == BIT_LAST) begin
                busy_d = 1'b0;
                stcp_d = 1'b1;
            end else begin
                // Next bit begins with shcp low; ds changes only here.
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                ds_d    = shreg_q[WIDTH-2];
                div_d   = '0;
                bit_d   = bit_q + BIT_W'(1);
            end
        end else begin
            div_d  = div_q + DIV_W'(1);
            ds_d   = ds_q;
            shcp_d = (div_d >= DIV_HALF);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            shreg_q <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b0;
            shcp_q  <= 1'b0;
            ds_q    <= 1'b0;
            stcp_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            busy_q  <= busy_d;
            shcp_q  <= shcp_d;
            ds_q    <= ds_d;
            stcp_q  <= stcp_d;
        end
    end

    assign done_o = busy_q && (bit_q == BIT_LAST) && (div_q == DIV_LAST);
    assign shcp_o = shcp_q;
    assign ds_o   = ds_q;
    assign stcp_o = stcp_q;

endmodule

// File: rtl/seg_595_dynamic.sv
// Multiplexed hex display driver: one digit slot per SCAN_CNT cycles, each
// slot serialises {one-hot select, segments} into a 595 chain and latches it.
module seg_595_dynamic
    import seg_pkg::*;
#(
    parameter int DIGITS   = 6,
    parameter int SCAN_CNT = 50000,
    parameter int SHCP_DIV = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     point,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  seg_en,
    output logic                  stcp,
    output logic                  shcp,
    output logic                  ds,
    output logic                  oe
);

    localparam int FRAME  = 8 + DIGITS;
    localparam int SCAN_W = $clog2(SCAN_CNT);
    localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CNT - 1);
    localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(DIGITS - 1);

    scan_state_t       state_q, state_d;
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [DIG_W-1:0]  digit_q, digit_d;
    logic              latched_q, latched_d;
    logic              oe_q, oe_d;

    logic [7:0]        seg_arr [DIGITS];
    logic [DIGITS-1:0] sel_vec;
    logic [7:0]        cur_seg;
    logic [FRAME-1:0]  shift_word;
    logic              shift_start;
    logic              shift_done;

    // Every digit is encoded in parallel; the scan index just picks one.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign seg_arr[gi] = encode_digit(data[4*gi +: 4], point[gi], blank[gi]);
        assign sel_vec[gi] = (digit_q == DIG_W'(gi)) ? SEL_ON : ~SEL_ON;
        assign shift_word[FRAME-1-gi] = sel_vec[gi];
    end

    assign cur_seg          = seg_arr[digit_q];
    assign shift_word[7:0]  = cur_seg;

    always_comb begin
        scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + SCAN_W'(1);
    end

    always_comb begin
        state_d     = state_q;
        digit_d     = digit_q;
        shift_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (scan_q == '0) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // The shifter captures shift_word on this edge.
                shift_start = 1'b1;
                state_d     = ST_SHIFT;
                digit_d     = (digit_q == DIG_LAST) ? '0 : digit_q + DIG_W'(1);
            end
            ST_SHIFT: begin
                if (shift_done) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Keep the 595 dark until it holds a real frame.
    always_comb begin
        latched_d = latched_q | (state_q == ST_LATCH);
        oe_d      = (latched_q || (state_q == ST_LATCH)) ? ~seg_en : 1'b1;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            scan_q    <= '0;
            digit_q   <= '0;
            latched_q <= 1'b0;
            oe_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            scan_q    <= scan_d;
            digit_q   <= digit_d;
            latched_q <= latched_d;
            oe_q      <= oe_d;
        end
    end

    hc595_shift #(
        .WIDTH    (FRAME),
        .SHCP_DIV (SHCP_DIV)
    ) u_shift (
        .clk     (sys_clk),
        .srst    (sys_rst),
        .start_i (shift_start),
        .word_i  (shift_word),
        .shcp_o  (shcp),
        .ds_o    (ds),
        .stcp_o  (stcp),
        .done_o  (shift_done)
    );

    assign oe = oe_q;

endmodule

// File: tb/tb_seg_595_dynamic.sv
// Directed bench for seg_595_dynamic: checks every cycle of each digit slot
// against hand-derived frames, oe behaviour and mid-frame reset.
module tb_seg_595_dynamic;

    localparam int DIGITS   = 6;
    localparam int SCAN_CNT = 64;
    localparam int SHCP_DIV = 4;
    localparam int FRAME    = 8 + DIGITS;
    localparam int LATCH_AT = 2 + FRAME * SHCP_DIV;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [23:0] data;
    logic [5:0]  point;
    logic [5:0]  blank;
    logic        seg_en;
    logic        stcp, shcp, ds, oe;

    int   n_vec = 0;
    int   n_err = 0;
    logic oe_model;
    logic latched_model;

    always #5 sys_clk = ~sys_clk;

    seg_595_dynamic #(
        .DIGITS   (DIGITS),
        .SCAN_CNT (SCAN_CNT),
        .SHCP_DIV (SHCP_DIV)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .data    (data),
        .point   (point),
        .blank   (blank),
        .seg_en  (seg_en),
        .stcp    (stcp),
        .shcp    (shcp),
        .ds      (ds),
        .oe      (oe)
    );

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Entered during a frame-start cycle t0; leaves at the next frame start.
    task automatic check_frame(
        input logic [5:0]  esel,
        input logic [7:0]  eseg,
        input string       tag,
        input int          chg_at,
        input logic [23:0] chg_data,
        input int          en_at,
        input logic        en_val
    );
        logic [FRAME-1:0] exp_w;
        logic [FRAME-1:0] obs_w;
        logic             stcp_exp;
        int               shcp_bad, ds_bad, stcp_bad, oe_bad;
        int               k, ph;
        exp_w      = '0;
        exp_w[7:0] = eseg;
        for (int i = 0; i < DIGITS; i++) exp_w[FRAME-1-i] = esel[i];
        obs_w    = '0;
        shcp_bad = 0;
        ds_bad   = 0;
        stcp_bad = 0;
        oe_bad   = 0;
        for (int c = 0; c < SCAN_CNT; c++) begin
            if (c >= 2 && c < LATCH_AT) begin
                k  = (c - 2) / SHCP_DIV;
                ph = (c - 2) % SHCP_DIV;
                if (shcp !== (ph >= SHCP_DIV / 2)) shcp_bad++;
                if (ds !== exp_w[FRAME-1-k]) ds_bad++;
                if (ph == SHCP_DIV / 2) obs_w[FRAME-1-k] = ds;
            end else begin
                if (shcp !== 1'b0) shcp_bad++;
                if (ds !== 1'b0) ds_bad++;
            end
            stcp_exp = (c == LATCH_AT);
            if (stcp !== stcp_exp) stcp_bad++;
            if (oe !== oe_model) oe_bad++;
            if (c == chg_at) data = chg_data;
            if (c == en_at) seg_en = en_val;
            oe_model      = (latched_model || stcp_exp) ? ~seg_en : 1'b1;
            latched_model = latched_model | stcp_exp;
            tick();
        end
        $display("frame %s: sel=%h seg=%h decoded=%h", tag, esel, eseg, obs_w);
        n_vec++;
        assert (obs_w === exp_w) else begin
            n_err++;
            $error("FAIL %s word: got %h want %h", tag, obs_w, exp_w);
        end
        n_vec++;
        assert (shcp_bad === 0) else begin
            n_err++;
            $error("FAIL %s shcp: got %0d bad cycles want 0", tag, shcp_bad);
        end
        n_vec++;
        assert (ds_bad === 0) else begin
            n_err++;
            $error("FAIL %s ds: got %0d bad cycles want 0", tag, ds_bad);
        end
        n_vec++;
        assert (stcp_bad === 0) else begin
            n_err++;
            $error("FAIL %s stcp: got %0d bad cycles want 0 (pulse at t0+%0d)", tag, stcp_bad, LATCH_AT);
        end
        n_vec++;
        assert (oe_bad === 0) else begin
            n_err++;
            $error("FAIL %s oe: got %0d bad cycles want 0", tag, oe_bad);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_vec++;
        assert ({stcp, shcp, ds, oe} === 4'b0001) else begin
            n_err++;
            $error("FAIL %s: got stcp/shcp/ds/oe=%b want 0001", tag, {stcp, shcp, ds, oe});
        end
    endtask

    initial begin
        sys_rst = 1'b1;
        data    = 24'h012345;
        point   = 6'b000000;
        blank   = 6'b000000;
        seg_en  = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");

        sys_rst       = 1'b0;
        oe_model      = 1'b1;
        latched_model = 1'b0;

        // First full refresh plus the wrap back to digit 0.
        check_frame(6'h01, 8'h92, "d0_first", -1, 24'h0, -1, 1'b1);
        check_frame(6'h02, 8'h99, "d1",       -1, 24'h0, -1, 1'b1);
        check_frame(6'h04, 8'hB0, "d2",       -1, 24'h0, -1, 1'b1);
        check_frame(6'h08, 8'hA4, "d3",       -1, 24'h0, -1, 1'b1);
        check_frame(6'h10, 8'hF9, "d4",       -1, 24'h0, -1, 1'b1);
        check_frame(6'h20, 8'hC0, "d5",       -1, 24'h0, -1, 1'b1);
        check_frame(6'h01, 8'h92, "d0_wrap",  -1, 24'h0, -1, 1'b1);

        point = 6'b000010;
        blank = 6'b100000;
        check_frame(6'h02, 8'h19, "d1_point", -1, 24'h0, -1, 1'b1);
        check_frame(6'h04, 8'hB0, "d2_pb",    -1, 24'h0, -1, 1'b1);
        check_frame(6'h08, 8'hA4, "d3_pb",    -1, 24'h0, -1, 1'b1);
        check_frame(6'h10, 8'hF9, "d4_pb",    -1, 24'h0, -1, 1'b1);
        check_frame(6'h20, 8'hFF, "d5_blank", -1, 24'h0, -1, 1'b1);

        check_frame(6'h01, 8'h92, "d0_midchg", 20, 24'h6789AB, -1, 1'b1);
        check_frame(6'h02, 8'h08, "d1_newdat", -1, 24'h0,      -1, 1'b1);

        check_frame(6'h04, 8'h90, "d2_en_off", -1, 24'h0, 5,  1'b0);
        n_vec++;
        assert (oe === 1'b1) else begin
            n_err++;
            $error("FAIL en_off_oe: got %b want %b", oe, 1'b1);
        end
        check_frame(6'h08, 8'h80, "d3_en_on",  -1, 24'h0, 10, 1'b1);
        n_vec++;
        assert (oe === 1'b0) else begin
            n_err++;
            $error("FAIL en_on_oe: got %b want %b", oe, 1'b0);
        end

        // Reset during digit 4's shift phase.
        repeat (30) tick();
        sys_rst = 1'b1;
        tick();
        check_reset_outputs("midrst_edge");
        repeat (2) tick();
        check_reset_outputs("midrst_hold");
        sys_rst       = 1'b0;
        oe_model      = 1'b1;
        latched_model = 1'b0;
        check_frame(6'h01, 8'h83, "d0_after_rst", -1, 24'h0, -1, 1'b1);
        check_frame(6'h02, 8'h08, "d1_after_rst", -1, 24'h0, -1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
